ps2_host_transmitter: RTL and testbench

- Host-to-device PS/2 command transmitter. It sends one byte from the host to the keyboard or mouse on the PS/2 AT0 port, for commands such as set-LEDs, reset and enable-reporting.
- It is the opposite direction of the existing device-to-host PS/2 receive path. It drives the same open-drain pins (clock/data pulldowns, clock/data inputs on GPIO[0..3]) and is instanced inside memory_io beside the receiver.
- Clocked by main_clk (90 MHz). It asserts rx_inhibit so the receiver ignores line activity during a transmission.

---
 rtl/ps2_host_transmitter.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter.
// Pulls the clock line low to inhibit the device, issues a request-to-send,
// then shifts out one byte, odd parity and stop bit on the device-generated
// clock, and checks the device's acknowledge bit. rx_inhibit stays high for
// the whole transfer so the receive path ignores line activity.
module ps2_host_transmitter #(
   parameter int INHIBIT_CYCLES = 9000,
   parameter int TIMEOUT_CYCLES = 1800000,
   parameter int SYNC_STAGES    = 2        // must be >= 2
) (
   input  logic       main_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit,
   output logic       ps2_clock_pulldown,
   output logic       ps2_data_pulldown,
   input  logic       ps2_clock_in,
   input  logic       ps2_data_in
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQUEST,
      SHIFT,
      WAIT_RELEASE
   } state_t;

   // Synchronised line levels
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   data_s;
   logic                   clk_fall;

   // Registered state and next-state values
   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [3:0]       edge_q,     edge_d;
   logic [7:0]       byte_q,     byte_d;
   logic             parity_q,   parity_d;
   logic             clock_pd_q, clock_pd_d;
   logic             data_pd_q,  data_pd_d;
   logic             done_q,     done_d;
   logic             error_q,    error_d;
   logic             ready_q,    ready_d;
   logic             inhibit_q,  inhibit_d;
   logic [3:0]       edge_inc;
   logic             timed_out;

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign data_s   = data_sync[SYNC_STAGES-1];
   assign clk_fall = clk_prev & ~clk_s;

   // Bring both raw lines into the main_clk domain and remember last clock level.
   // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clock_in};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge main_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         edge_q     <= '0;
         byte_q     <= '0;
         parity_q   <= 1'b0;
         clock_pd_q <= 1'b0;
         data_pd_q  <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         ready_q    <= 1'b1;
         inhibit_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         edge_q     <= edge_d;
         byte_q     <= byte_d;
         parity_q   <= parity_d;
         clock_pd_q <= clock_pd_d;
         data_pd_q  <= data_pd_d;
         done_q     <= done_d;
         error_q    <= error_d;
         ready_q    <= ready_d;
         inhibit_q  <= inhibit_d;
      end
   end

   // Next-state logic: inhibit, request-to-send, bit shifting, ack and timeout.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      edge_d     = edge_q;
      byte_d     = byte_q;
      parity_d   = parity_q;
      clock_pd_d = clock_pd_q;
      data_pd_d  = data_pd_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      edge_inc   = edge_q + 4'd1;
      timed_out  = (cnt_q == TIMEOUT_LAST);

      case (state_q)
         IDLE: begin
            clock_pd_d = 1'b0;
            data_pd_d  = 1'b0;
            if (tx_valid && ready_q) begin
               byte_d     = tx_data;
               parity_d   = ~^tx_data;
               cnt_d      = '0;
               clock_pd_d = 1'b1;
               state_d    = INHIBIT;
            end
         end

         INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               data_pd_d = 1'b1;          // start bit while clock still held low
               state_d   = REQUEST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         REQUEST: begin
            clock_pd_d = 1'b0;            // hand the clock to the device
            cnt_d      = '0;              // timeout runs from clock release
            edge_d     = '0;
            state_d    = SHIFT;
         end

         SHIFT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timed_out) begin
               error_d   = 1'b1;
               data_pd_d = 1'b0;
               state_d   = IDLE;
            end else if (clk_fall) begin
               edge_d = edge_inc;
               case (edge_inc)
                  4'd9:    data_pd_d = ~parity_q;
                  4'd10:   data_pd_d = 1'b0;  // stop bit: release data
                  4'd11: begin
                     if (data_s) begin
                        error_d = 1'b1;       // device did not acknowledge
                        state_d = IDLE;
                     end else begin
                        state_d = WAIT_RELEASE;
                     end
                  end
                  default: data_pd_d = ~byte_q[edge_q[2:0]];  // edges 1..8, LSB first
               endcase
            end
         end

         WAIT_RELEASE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timed_out) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else if (clk_s && data_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            clock_pd_d = 1'b0;
            data_pd_d  = 1'b0;
            state_d    = IDLE;
         end
      endcase

      // Ready only rises the cycle after a done/error pulse.
      ready_d   = (state_d == IDLE) && !done_d && !error_d;
      inhibit_d = (state_d != IDLE);
   end

   assign tx_ready           = ready_q;
   assign tx_done            = done_q;
   assign tx_error           = error_q;
   assign rx_inhibit         = inhibit_q;
   assign ps2_clock_pulldown = clock_pd_q;
   assign ps2_data_pulldown  = data_pd_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench for ps2_host_transmitter with a PS/2 device model on
// open-drain lines. Timing parameters are scaled down to keep runs short.
module tb_ps2_host_transmitter;

   localparam int INH  = 60;
   localparam int TMO  = 3000;
   localparam int HALF = 20;   // device clock half-period in main_clk cycles

   logic       main_clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_error, rx_inhibit;
   logic       ps2_clock_pulldown, ps2_data_pulldown;
   logic       ps2_clock_in, ps2_data_in;
   logic       dev_clk_low, dev_data_low;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int overlap_cnt = 0;

   // Wired-AND open-drain lines with pull-ups
   assign ps2_clock_in = ~(ps2_clock_pulldown | dev_clk_low);
   assign ps2_data_in  = ~(ps2_data_pulldown | dev_data_low);

   ps2_host_transmitter #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .SYNC_STAGES(2)
   ) dut (
      .main_clk(main_clk),
      .reset(reset),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_done(tx_done),
      .tx_error(tx_error),
      .rx_inhibit(rx_inhibit),
      .ps2_clock_pulldown(ps2_clock_pulldown),
      .ps2_data_pulldown(ps2_data_pulldown),
      .ps2_clock_in(ps2_clock_in),
      .ps2_data_in(ps2_data_in)
   );

   always #5 main_clk = ~main_clk;

   // Pulse counters
   always @(negedge main_clk) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) overlap_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         poke;
      logic [9:0] frame;   // line level at edges 1..10, edge1 in bit 0
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame the device should see: 8 data bits LSB first, odd parity, stop=1.
   function automatic logic [9:0] frame_model(input logic [7:0] b);
      int  ones;
      logic par;
      ones = $countones(b);
      par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, b};
   endfunction

   // Device: wait for request-to-send, clock n_edges bits, optionally ack.
   task automatic run_device(input int n_edges, input bit ack, output logic [9:0] seen);
      int guard;
      seen  = '0;
      guard = 0;
      while ((ps2_clock_pulldown || !ps2_data_pulldown) && guard < INH + 100) begin
         @(negedge main_clk);
         guard++;
      end
      check("dev_rts_seen", guard < INH + 100, 1);
      repeat (10) @(negedge main_clk);
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 11 && ack) begin
            dev_data_low = 1'b1;
            repeat (3) @(negedge main_clk);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge main_clk);
         if (e <= 10) seen[e-1] = ps2_data_in;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge main_clk);
      end
      dev_data_low = 1'b0;
   endtask

   // Issue a request and verify inhibit / request-to-send timing.
   task automatic start_and_measure(input logic [7:0] b);
      int cnt;
      bit inh_ok;
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge main_clk);
      tx_valid = 1'b0;
      tx_data  = ~b;
      cnt    = 0;
      inh_ok = 1'b1;
      while (ps2_clock_pulldown && !ps2_data_pulldown && cnt < INH + 10) begin
         inh_ok &= rx_inhibit;
         cnt++;
         @(negedge main_clk);
      end
      check("inhibit_len", cnt, INH);
      check("request_cycle", {ps2_clock_pulldown, ps2_data_pulldown}, 2'b11);
      inh_ok &= rx_inhibit;
      @(negedge main_clk);
      check("clock_release", {ps2_clock_pulldown, ps2_data_pulldown}, 2'b01);
      check("rx_inhibit_held", inh_ok & rx_inhibit, 1);
   endtask

   task automatic wait_end(input bit exp_done);
      int guard;
      guard = 0;
      while (!(tx_done || tx_error) && guard < 2000) begin
         @(negedge main_clk);
         guard++;
      end
      check("end_pulse_seen", guard < 2000, 1);
      check("end_kind_done", tx_done, exp_done);
      check("end_pulldowns", {ps2_clock_pulldown, ps2_data_pulldown}, 0);
      check("ready_in_pulse", tx_ready, 0);
      @(negedge main_clk);
      check("ready_after_pulse", tx_ready, 1);
      check("pulse_one_cycle", tx_done | tx_error, 0);
   endtask

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!tx_ready && guard < 100) begin
         @(negedge main_clk);
         guard++;
      end
      check("ready_before", tx_ready, 1);
   endtask

   task automatic do_transfer(input logic [7:0] b, input bit ack, input bit poke,
                              input logic [9:0] exp_frame);
      int d0, e0;
      logic [9:0] seen;
      wait_ready();
      d0 = done_cnt;
      e0 = err_cnt;
      start_and_measure(b);
      fork
         run_device(11, ack, seen);
         wait_end(ack);
         begin
            if (poke) begin
               repeat (150) @(negedge main_clk);
               tx_data  = b ^ 8'h5A;
               tx_valid = 1'b1;
               @(negedge main_clk);
               tx_valid = 1'b0;
            end
         end
      join
      repeat (20) @(negedge main_clk);
      check("frame", seen, exp_frame);
      check("done_count", done_cnt - d0, ack);
      check("error_count", err_cnt - e0, !ack);
   endtask

   initial begin
      logic [7:0] rb;
      bit         rack;
      logic [9:0] seen;
      int         d0, e0, cnt;

      vecs[0] = '{8'hF4, 1'b1, 1'b0, 10'h2F4};
      vecs[1] = '{8'hFF, 1'b1, 1'b0, 10'h3FF};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 10'h300};
      vecs[3] = '{8'hAA, 1'b0, 1'b0, 10'h3AA};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 10'h201};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 10'h280};

      reset        = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge main_clk);
      check("rst_ready", tx_ready, 1);
      check("rst_done", tx_done, 0);
      check("rst_error", tx_error, 0);
      check("rst_inhibit", rx_inhibit, 0);
      check("rst_pulldowns", {ps2_clock_pulldown, ps2_data_pulldown}, 0);
      reset = 1'b0;
      repeat (2) @(negedge main_clk);
      check("post_rst_ready", tx_ready, 1);

      // Directed table
      for (int i = 0; i < 6; i++)
         do_transfer(vecs[i].data, vecs[i].ack, vecs[i].poke, vecs[i].frame);

      // Random bytes against the frame model
      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom_range(0, 255));
         rack = 1'($urandom_range(0, 1));
         do_transfer(rb, rack, 1'b0, frame_model(rb));
      end

      // Silent device: timeout measured from clock release
      wait_ready();
      d0 = done_cnt;
      start_and_measure(8'h5A);
      cnt = 0;
      while (!tx_error && cnt < TMO + 50) begin
         @(negedge main_clk);
         cnt++;
      end
      check("timeout_len", cnt, TMO);
      check("timeout_pulldowns", {ps2_clock_pulldown, ps2_data_pulldown}, 0);
      @(negedge main_clk);
      check("timeout_ready_next", tx_ready, 1);
      check("timeout_no_done", done_cnt - d0, 0);

      // Reset during inhibit releases the clock line asynchronously
      wait_ready();
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      @(negedge main_clk);
      tx_valid = 1'b0;
      repeat (10) @(negedge main_clk);
      check("inhibit_clock_low", ps2_clock_pulldown, 1);
      #2 reset = 1'b1;
      #1 check("async_rst_inhibit", {ps2_clock_pulldown, ps2_data_pulldown}, 0);
      repeat (3) @(negedge main_clk);
      reset = 1'b0;
      repeat (2) @(negedge main_clk);

      // Reset after 4 device edges, then a full 0xED transfer with a stray request
      wait_ready();
      d0 = done_cnt;
      e0 = err_cnt;
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge main_clk);
      tx_valid = 1'b0;
      run_device(4, 1'b0, seen);
      check("shift_data_low", ps2_data_pulldown, 1);
      #2 reset = 1'b1;
      #1 check("async_rst_shift", {ps2_clock_pulldown, ps2_data_pulldown}, 0);
      check("async_rst_ready", tx_ready, 1);
      repeat (3) @(negedge main_clk);
      reset = 1'b0;
      repeat (20) @(negedge main_clk);
      check("abort_ready", tx_ready, 1);
      check("abort_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      do_transfer(8'hED, 1'b1, 1'b1, 10'h3ED);

      check("never_both", overlap_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
